sdram_port_arbiter: RTL and testbench

- Two-port round-robin arbiter that shares the single-beat host interface of the SDRAM controller between two requesters, e.g. a test/debug interface and a DMA-style client.
- Sequences each access: latch request, pulse rd_enable/wr_enable, track busy, capture read data, acknowledge the winner.
- Sits directly between the requesters and the controller's haddr/data_input/data_output/busy/rd_enable/wr_enable pins.

---
 rtl/sdram_port_arbiter_if.sv | 47 ++++
 rtl/sdram_port_arbiter.sv | 110 +++++++++++
 tb/tb_sdram_port_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_port_arbiter_if.sv
// Bundle of requester-side and controller-side signals around the two-port SDRAM arbiter.
// The slave modport is the arbiter's view; master is the requesters plus the controller.
interface sdram_port_arbiter_if #(
  parameter int HADDR_WIDTH = 24
);
  logic                   p0_req;
  logic                   p0_we;
  logic [HADDR_WIDTH-1:0] p0_addr;
  logic [15:0]            p0_wdata;
  logic                   p0_ack;
  logic [15:0]            p0_rdata;

  logic                   p1_req;
  logic                   p1_we;
  logic [HADDR_WIDTH-1:0] p1_addr;
  logic [15:0]            p1_wdata;
  logic                   p1_ack;
  logic [15:0]            p1_rdata;

  logic                   timeout_err;
  logic                   grant;

  logic [HADDR_WIDTH-1:0] haddr;
  logic [15:0]            data_input;
  logic [15:0]            data_output;
  logic                   busy;
  logic                   rd_enable;
  logic                   wr_enable;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    input  data_output, busy,
    output p0_ack, p0_rdata, p1_ack, p1_rdata,
    output timeout_err, grant,
    output haddr, data_input, rd_enable, wr_enable
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    output data_output, busy,
    input  p0_ack, p0_rdata, p1_ack, p1_rdata,
    input  timeout_err, grant,
    input  haddr, data_input, rd_enable, wr_enable
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing the SDRAM controller's single-beat host port between two
// requesters; sequences issue, busy tracking, read capture and a one-cycle acknowledge.
module sdram_port_arbiter #(
  parameter int HADDR_WIDTH   = 24,
  parameter int TIMEOUT_WIDTH = 4
) (
  input logic                clk,
  input logic                rst_n,
  sdram_port_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, DONE} state_t;

  state_t                   state;
  logic                     last_grant;
  logic                     we;
  logic [TIMEOUT_WIDTH-1:0] wd_cnt;
  logic [TIMEOUT_WIDTH-1:0] wd_next;

  logic                     any_req;
  logic                     sel_port;
  logic                     sel_we;
  logic [HADDR_WIDTH-1:0]   sel_addr;
  logic [15:0]              sel_wdata;

  // NOTE: every signal gets a default at the top so no path through this block infers a latch.
  always_comb begin
    any_req   = bus.p0_req | bus.p1_req;
    sel_port  = 1'b0;
    if (bus.p0_req && bus.p1_req) sel_port = ~last_grant;
    else                          sel_port = bus.p1_req;
    sel_we    = sel_port ? bus.p1_we    : bus.p0_we;
    sel_addr  = sel_port ? bus.p1_addr  : bus.p0_addr;
    sel_wdata = sel_port ? bus.p1_wdata : bus.p0_wdata;
  end

  assign wd_next = wd_cnt + TIMEOUT_WIDTH'(1);

  // NOTE: all state and outputs use <= so each register updates from pre-edge values only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      last_grant      <= 1'b1;
      we              <= 1'b0;
      wd_cnt          <= '0;
      bus.grant       <= 1'b0;
      bus.haddr       <= '0;
      bus.data_input  <= '0;
      bus.rd_enable   <= 1'b0;
      bus.wr_enable   <= 1'b0;
      bus.p0_ack      <= 1'b0;
      bus.p1_ack      <= 1'b0;
      bus.p0_rdata    <= '0;
      bus.p1_rdata    <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.busy && any_req) begin
            bus.grant     <= sel_port;
            bus.haddr     <= sel_addr;
            we            <= sel_we;
            if (sel_we) bus.data_input <= sel_wdata;
            bus.rd_enable <= ~sel_we;
            bus.wr_enable <= sel_we;
            state         <= ISSUE;
          end
        end
        ISSUE: begin
          bus.rd_enable <= 1'b0;
          bus.wr_enable <= 1'b0;
          last_grant    <= bus.grant;
          wd_cnt        <= '0;
          state         <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (bus.busy) begin
            state <= WAIT_DONE;
          end else begin
            wd_cnt <= wd_next;
            // Controller never answered: still acknowledge so the requester cannot hang.
            if (&wd_next) begin
              bus.timeout_err <= 1'b1;
              bus.p0_ack      <= ~bus.grant;
              bus.p1_ack      <= bus.grant;
              state           <= DONE;
            end
          end
        end
        WAIT_DONE: begin
          if (!bus.busy) begin
            if (!we) begin
              if (bus.grant) bus.p1_rdata <= bus.data_output;
              else           bus.p0_rdata <= bus.data_output;
            end
            bus.p0_ack <= ~bus.grant;
            bus.p1_ack <= bus.grant;
            state      <= DONE;
          end
        end
        DONE: begin
          bus.p0_ack      <= 1'b0;
          bus.p1_ack      <= 1'b0;
          bus.timeout_err <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: emulates the SDRAM controller and two requesters, and checks
// directed scenarios plus random traffic against a transaction-level round-robin model.
module tb_sdram_port_arbiter;
  localparam int AW = 24;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.HADDR_WIDTH(AW)) bus ();

  sdram_port_arbiter #(.HADDR_WIDTH(AW), .TIMEOUT_WIDTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller emulation knobs
  logic ctrl_busy;
  logic ext_busy;
  bit   never_busy;
  int   busy_delay;
  int   busy_len;
  logic [15:0] ctrl_mem [logic [AW-1:0]];
  assign bus.busy = ctrl_busy | ext_busy;

  // Contents of a never-written location, known to controller and model alike.
  function automatic logic [15:0] blank_word(logic [AW-1:0] a);
    return a[15:0] ^ 16'hC3A5;
  endfunction

  initial begin
    int phase;
    int cnt;
    logic c_rd;
    logic [AW-1:0] c_addr;
    phase = 0; cnt = 0; c_rd = 1'b0; c_addr = '0;
    ctrl_busy = 1'b0;
    bus.data_output = '0;
    forever begin
      @(posedge clk); #1;
      bus.data_output = 16'($urandom);
      if (!rst_n) begin
        ctrl_busy = 1'b0;
        phase = 0;
      end else begin
        case (phase)
          0: if (bus.rd_enable || bus.wr_enable) begin
               c_rd = bus.rd_enable;
               c_addr = bus.haddr;
               if (!never_busy) begin
                 if (bus.wr_enable) ctrl_mem[bus.haddr] = bus.data_input;
                 cnt = busy_delay;
                 phase = 1;
               end
             end
          1: begin
               cnt--;
               if (cnt == 0) begin ctrl_busy = 1'b1; cnt = busy_len; phase = 2; end
             end
          default: begin
               cnt--;
               if (cnt == 0) begin
                 ctrl_busy = 1'b0;
                 phase = 0;
                 if (c_rd) bus.data_output = ctrl_mem.exists(c_addr) ? ctrl_mem[c_addr] : blank_word(c_addr);
               end
             end
        endcase
      end
    end
  end

  typedef struct {
    int start_cyc, en_cyc, ack_cyc, low_cyc;
    int en_count, rd_count, wr_count;
    logic [AW-1:0] en_addr;
    logic [15:0] en_data;
    logic ack0, ack1, terr, grant;
    logic [15:0] rd0, rd1;
    bit held;
    bit expired;
  } obs_t;

  // Observes one transaction at negedges until an ack appears or the budget runs out.
  task automatic watch(input int budget, output obs_t o);
    bit seen_busy;
    o = '{default: 0};
    o.start_cyc = cyc; o.en_cyc = -1; o.ack_cyc = -1; o.low_cyc = -1;
    o.held = 1'b1; o.expired = 1'b1;
    seen_busy = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.rd_enable || bus.wr_enable) begin
        if (o.en_count == 0) begin
          o.en_cyc = cyc; o.en_addr = bus.haddr; o.en_data = bus.data_input;
        end
        o.en_count++;
        if (bus.rd_enable) o.rd_count++;
        if (bus.wr_enable) o.wr_count++;
      end
      if (o.en_count > 0 && (bus.haddr !== o.en_addr || bus.data_input !== o.en_data)) o.held = 1'b0;
      if (bus.busy) seen_busy = 1'b1;
      else if (seen_busy && o.low_cyc < 0) o.low_cyc = cyc;
      if (bus.p0_ack || bus.p1_ack) begin
        o.ack_cyc = cyc; o.ack0 = bus.p0_ack; o.ack1 = bus.p1_ack;
        o.terr = bus.timeout_err; o.grant = bus.grant;
        o.rd0 = bus.p0_rdata; o.rd1 = bus.p1_rdata;
        o.expired = 1'b0;
        break;
      end
    end
  endtask

  task automatic clear_ports();
    bus.p0_req = 0; bus.p0_we = 0; bus.p0_addr = '0; bus.p0_wdata = '0;
    bus.p1_req = 0; bus.p1_we = 0; bus.p1_addr = '0; bus.p1_wdata = '0;
  endtask

  task automatic apply_reset();
    clear_ports();
    ext_busy = 0; never_busy = 0; busy_delay = 1; busy_len = 5;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_ports();
    ext_busy = 0; never_busy = 0; busy_delay = 1; busy_len = 5;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.haddr !== '0) begin n_fail++; $display("FAIL reset_haddr: got %h want 0", bus.haddr); end
    n_checks++; if (bus.data_input !== 16'h0) begin n_fail++; $display("FAIL reset_data_input: got %h want 0", bus.data_input); end
    n_checks++; if ({bus.rd_enable, bus.wr_enable} !== 2'b00) begin n_fail++; $display("FAIL reset_enables: got %b want 00", {bus.rd_enable, bus.wr_enable}); end
    n_checks++; if ({bus.p0_ack, bus.p1_ack, bus.timeout_err, bus.grant} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {bus.p0_ack, bus.p1_ack, bus.timeout_err, bus.grant}); end
    n_checks++; if ({bus.p0_rdata, bus.p1_rdata} !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", {bus.p0_rdata, bus.p1_rdata}); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if ({bus.rd_enable, bus.wr_enable, bus.p0_ack, bus.p1_ack} !== 4'b0) begin n_fail++; $display("FAIL reset_idle_quiet: got %b want 0000", {bus.rd_enable, bus.wr_enable, bus.p0_ack, bus.p1_ack}); end
  endtask

  task automatic test_single_write();
    obs_t o;
    apply_reset();
    bus.p0_req = 1; bus.p0_we = 1; bus.p0_addr = 24'h000123; bus.p0_wdata = 16'hA5A5;
    watch(40, o);
    n_checks++; if (o.expired) begin n_fail++; $display("FAIL wr_ack_seen: got none want p0_ack"); end
    n_checks++; if (o.wr_count !== 1 || o.rd_count !== 0) begin n_fail++; $display("FAIL wr_pulses: got wr=%0d rd=%0d want wr=1 rd=0", o.wr_count, o.rd_count); end
    n_checks++; if (o.en_addr !== 24'h000123) begin n_fail++; $display("FAIL wr_haddr: got %h want 000123", o.en_addr); end
    n_checks++; if (o.en_data !== 16'hA5A5) begin n_fail++; $display("FAIL wr_data_input: got %h want a5a5", o.en_data); end
    n_checks++; if (o.en_cyc - o.start_cyc !== 1) begin n_fail++; $display("FAIL wr_issue_latency: got %0d want 1", o.en_cyc - o.start_cyc); end
    n_checks++; if ({o.ack0, o.ack1} !== 2'b10) begin n_fail++; $display("FAIL wr_ack_port: got p0=%b p1=%b want p0=1 p1=0", o.ack0, o.ack1); end
    // ack lands in the cycle right after the first cycle busy is seen low
    n_checks++; if (o.ack_cyc - o.low_cyc !== 1) begin n_fail++; $display("FAIL wr_ack_latency: got %0d want 1", o.ack_cyc - o.low_cyc); end
    n_checks++; if (!o.held) begin n_fail++; $display("FAIL wr_bus_held: got changed want stable haddr/data_input"); end
    n_checks++; if (o.terr !== 1'b0) begin n_fail++; $display("FAIL wr_timeout_err: got %b want 0", o.terr); end
    bus.p0_req = 0;
    watch(8, o);
    n_checks++; if (!o.expired || o.en_count !== 0) begin n_fail++; $display("FAIL wr_no_reserve: got acks=%0d enables=%0d want 0 0", !o.expired, o.en_count); end
  endtask

  task automatic test_read_capture();
    obs_t o;
    apply_reset();
    ctrl_mem[24'h00FFFF] = 16'h5A3C;
    busy_delay = 2; busy_len = 3;
    bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 24'h00FFFF; bus.p1_wdata = 16'hFFFF;
    watch(40, o);
    n_checks++; if ({o.ack0, o.ack1} !== 2'b01) begin n_fail++; $display("FAIL rd_ack_port: got p0=%b p1=%b want p0=0 p1=1", o.ack0, o.ack1); end
    n_checks++; if (o.rd1 !== 16'h5A3C) begin n_fail++; $display("FAIL rd_p1_rdata: got %h want 5a3c", o.rd1); end
    n_checks++; if (o.rd0 !== 16'h0) begin n_fail++; $display("FAIL rd_p0_untouched: got %h want 0", o.rd0); end
    n_checks++; if (o.rd_count !== 1 || o.wr_count !== 0) begin n_fail++; $display("FAIL rd_pulses: got rd=%0d wr=%0d want rd=1 wr=0", o.rd_count, o.wr_count); end
    n_checks++; if (o.grant !== 1'b1) begin n_fail++; $display("FAIL rd_grant: got %b want 1", o.grant); end
    n_checks++; if (o.en_data !== 16'h0) begin n_fail++; $display("FAIL rd_data_input_kept: got %h want 0", o.en_data); end
    bus.p1_req = 0;
  endtask

  task automatic test_fairness();
    obs_t o;
    apply_reset();
    busy_delay = 1; busy_len = 2;
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 24'h000010;
    bus.p1_req = 1; bus.p1_we = 0; bus.p1_addr = 24'h000020;
    for (int i = 0; i < 4; i++) begin
      logic exp_g;
      exp_g = 1'(i % 2);
      watch(40, o);
      n_checks++; if (o.grant !== exp_g) begin n_fail++; $display("FAIL fair_grant[%0d]: got %b want %b", i, o.grant, exp_g); end
      n_checks++; if ({o.ack0, o.ack1} !== {~exp_g, exp_g}) begin n_fail++; $display("FAIL fair_ack[%0d]: got %b want %b", i, {o.ack0, o.ack1}, {~exp_g, exp_g}); end
      n_checks++; if (o.en_count !== 1) begin n_fail++; $display("FAIL fair_enables[%0d]: got %0d want 1", i, o.en_count); end
      if (i > 0) begin
        n_checks++; if (o.en_cyc - o.start_cyc !== 2) begin n_fail++; $display("FAIL fair_turnaround[%0d]: got %0d want 2", i, o.en_cyc - o.start_cyc); end
      end
    end
    clear_ports();
  endtask

  task automatic test_busy_at_request();
    obs_t o;
    int seen;
    apply_reset();
    ext_busy = 1;
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 24'h000077;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rd_enable || bus.wr_enable) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL busy_no_issue: got %0d enables want 0", seen); end
    ext_busy = 0;
    watch(40, o);
    n_checks++; if (o.en_cyc - o.start_cyc !== 1) begin n_fail++; $display("FAIL busy_issue_latency: got %0d want 1", o.en_cyc - o.start_cyc); end
    n_checks++; if (o.rd_count !== 1 || o.ack0 !== 1'b1) begin n_fail++; $display("FAIL busy_served: got rd=%0d ack0=%b want 1 1", o.rd_count, o.ack0); end
    bus.p0_req = 0;
  endtask

  task automatic test_timeout();
    obs_t o;
    apply_reset();
    ctrl_mem[24'h000040] = 16'h1234;
    ctrl_mem[24'h000042] = 16'hBEEF;
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 24'h000040;
    watch(40, o);
    n_checks++; if (o.rd0 !== 16'h1234) begin n_fail++; $display("FAIL to_prime_read: got %h want 1234", o.rd0); end
    never_busy = 1;
    bus.p0_addr = 24'h000041;
    watch(40, o);
    n_checks++; if (o.expired || o.ack0 !== 1'b1) begin n_fail++; $display("FAIL to_ack: got ack0=%b want 1", o.ack0); end
    n_checks++; if (o.terr !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b want 1", o.terr); end
    // 15 cycles waiting for busy after the issue cycle, ack on the next
    n_checks++; if (o.ack_cyc - o.en_cyc !== 16) begin n_fail++; $display("FAIL to_latency: got %0d want 16", o.ack_cyc - o.en_cyc); end
    n_checks++; if (o.rd0 !== 16'h1234) begin n_fail++; $display("FAIL to_rdata_kept: got %h want 1234", o.rd0); end
    never_busy = 0;
    bus.p0_addr = 24'h000042;
    watch(40, o);
    n_checks++; if (o.expired || o.terr !== 1'b0 || o.rd0 !== 16'hBEEF) begin n_fail++; $display("FAIL to_recover: got ack=%b terr=%b rdata=%h want 1 0 beef", !o.expired, o.terr, o.rd0); end
    bus.p0_req = 0;
  endtask

  task automatic test_reset_mid_op();
    obs_t o;
    int busy_seen;
    apply_reset();
    busy_len = 20;
    bus.p0_req = 1; bus.p0_we = 0; bus.p0_addr = 24'h000055;
    busy_seen = 0;
    for (int i = 0; i < 10 && busy_seen < 2; i++) begin
      @(negedge clk);
      if (bus.busy) busy_seen++;
    end
    n_checks++; if (busy_seen < 2) begin n_fail++; $display("FAIL rst_reach_wait_done: got %0d busy cycles want 2", busy_seen); end
    rst_n = 1'b0;
    bus.p0_req = 0;
    @(negedge clk);
    n_checks++; if ({bus.rd_enable, bus.wr_enable, bus.p0_ack, bus.p1_ack, bus.timeout_err, bus.grant} !== 6'b0) begin n_fail++; $display("FAIL rst_flags: got %b want 000000", {bus.rd_enable, bus.wr_enable, bus.p0_ack, bus.p1_ack, bus.timeout_err, bus.grant}); end
    n_checks++; if (bus.haddr !== '0 || bus.data_input !== 16'h0) begin n_fail++; $display("FAIL rst_bus: got haddr=%h din=%h want 0 0", bus.haddr, bus.data_input); end
    rst_n = 1'b1;
    busy_len = 3;
    watch(12, o);
    n_checks++; if (!o.expired || o.en_count !== 0) begin n_fail++; $display("FAIL rst_no_stale_ack: got ack=%b enables=%0d want 0 0", !o.expired, o.en_count); end
    bus.p0_req = 1; bus.p0_addr = 24'h000056;
    watch(40, o);
    n_checks++; if (o.expired || o.ack0 !== 1'b1 || o.rd0 !== blank_word(24'h000056)) begin n_fail++; $display("FAIL rst_new_txn: got ack0=%b rdata=%h want 1 %h", o.ack0, o.rd0, blank_word(24'h000056)); end
    bus.p0_req = 0;
  endtask

  // Random traffic: model keeps pending requests, last winner, memory image and per-port rdata.
  bit            pend [2];
  logic          m_we [2];
  logic [AW-1:0] m_addr [2];
  logic [15:0]   m_wdata [2];

  task automatic new_req(input int p);
    pend[p] = 1'b1;
    m_we[p] = 1'($urandom_range(0, 1));
    m_addr[p] = AW'($urandom_range(0, 7) * 16);
    m_wdata[p] = 16'($urandom);
  endtask

  task automatic drive_ports();
    bus.p0_req = pend[0]; bus.p0_we = m_we[0]; bus.p0_addr = m_addr[0]; bus.p0_wdata = m_wdata[0];
    bus.p1_req = pend[1]; bus.p1_we = m_we[1]; bus.p1_addr = m_addr[1]; bus.p1_wdata = m_wdata[1];
  endtask

  task automatic test_random();
    obs_t o;
    logic [15:0] ref_mem [logic [AW-1:0]];
    logic [15:0] ref_rd [2];
    logic [15:0] exp_din;
    int last;
    int w;
    apply_reset();
    ctrl_mem.delete();
    last = 1; exp_din = '0; ref_rd[0] = '0; ref_rd[1] = '0;
    pend[0] = 0; pend[1] = 0;
    for (int p = 0; p < 2; p++) if ($urandom_range(0, 1) == 1) new_req(p);
    if (!pend[0] && !pend[1]) new_req(int'($urandom_range(0, 1)));
    drive_ports();
    for (int t = 0; t < 40; t++) begin
      busy_delay = int'($urandom_range(1, 3));
      busy_len = int'($urandom_range(1, 6));
      w = (pend[0] && pend[1]) ? 1 - last : (pend[0] ? 0 : 1);
      watch(60, o);
      n_checks++; if (o.expired) begin n_fail++; $display("FAIL rnd_ack_seen[%0d]: got none want ack", t); end
      n_checks++; if (o.grant !== 1'(w)) begin n_fail++; $display("FAIL rnd_grant[%0d]: got %b want %0d", t, o.grant, w); end
      n_checks++; if ({o.ack1, o.ack0} !== 2'(1 << w)) begin n_fail++; $display("FAIL rnd_ack_port[%0d]: got p1p0=%b want port %0d", t, {o.ack1, o.ack0}, w); end
      n_checks++; if (o.en_count !== 1 || o.wr_count !== int'(m_we[w])) begin n_fail++; $display("FAIL rnd_enable[%0d]: got en=%0d wr=%0d want 1 %0d", t, o.en_count, o.wr_count, m_we[w]); end
      n_checks++; if (o.en_addr !== m_addr[w]) begin n_fail++; $display("FAIL rnd_haddr[%0d]: got %h want %h", t, o.en_addr, m_addr[w]); end
      if (m_we[w]) begin
        exp_din = m_wdata[w];
        ref_mem[m_addr[w]] = m_wdata[w];
      end else begin
        ref_rd[w] = ref_mem.exists(m_addr[w]) ? ref_mem[m_addr[w]] : blank_word(m_addr[w]);
      end
      n_checks++; if (o.en_data !== exp_din) begin n_fail++; $display("FAIL rnd_data_input[%0d]: got %h want %h", t, o.en_data, exp_din); end
      n_checks++; if (o.rd0 !== ref_rd[0] || o.rd1 !== ref_rd[1]) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h/%h want %h/%h", t, o.rd0, o.rd1, ref_rd[0], ref_rd[1]); end
      n_checks++; if (o.terr !== 1'b0 || !o.held) begin n_fail++; $display("FAIL rnd_clean[%0d]: got terr=%b held=%b want 0 1", t, o.terr, o.held); end
      last = w;
      if ($urandom_range(0, 3) == 0) pend[w] = 1'b0;
      else new_req(w);
      if (!pend[1 - w] && $urandom_range(0, 1) == 1) new_req(1 - w);
      if (!pend[0] && !pend[1]) new_req(int'($urandom_range(0, 1)));
      drive_ports();
    end
    clear_ports();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "bench did not terminate");
  end

  initial begin
    rst_n = 1'b0;
    ext_busy = 0; never_busy = 0; busy_delay = 1; busy_len = 5;
    clear_ports();
    test_reset();
    test_single_write();
    test_read_capture();
    test_fairness();
    test_busy_at_request();
    test_timeout();
    test_reset_mid_op();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
